// File: rtl/alu_result_stage.sv
// alu_result_stage: picks one of four ALU results by opcode and queues it,
// together with its overflow/error flags and the opcode tag, in a 2-entry
// buffer. The buffer feeds a valid/ready handshake to the consumer.
// A wrapping counter records every accepted operation.
// Optional macro ALU_STICKY_FLAGS_EN adds sticky overflow/error flags.
// Without the macro those outputs are tied low and i_clr_flags is ignored.
module alu_result_stage #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_sel,
  input  logic [4*WIDTH-1:0] i_y_all,
  input  logic [3:0]         i_ovf_all,
  input  logic [3:0]         i_err_all,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_y,
  output logic               o_overflow,
  output logic               o_err,
  output logic [1:0]         o_sel,
  output logic [CNT_W-1:0]   o_op_cnt,
  input  logic               i_clr_flags,
  output logic               o_sticky_ovf,
  output logic               o_sticky_err
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             ovf;
    logic             err;
    logic [1:0]       sel;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state;
  entry_t           head, tail, in_ent;
  logic             vld_q, rdy_q;
  logic [CNT_W-1:0] cnt;
  logic             push, pop;

  // Handshakes use only the registered valid/ready, so there is no
  // combinational path from i_valid or i_ready to any output.
  assign push = i_valid && rdy_q;
  assign pop  = vld_q && i_ready;

  // Select the addressed result slice and its flags
  always_comb begin
    in_ent     = '0;
    in_ent.y   = i_y_all[i_sel*WIDTH +: WIDTH];
    in_ent.ovf = i_ovf_all[i_sel];
    in_ent.err = i_err_all[i_sel];
    in_ent.sel = i_sel;
  end

  // Buffer control. head always feeds the outputs directly, and tail only
  // holds the second entry while the buffer is FULL. valid/ready are kept as
  // their own registers and updated together with the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
      vld_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= in_ent;
            state <= ONE;
            vld_q <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= in_ent;
          end else if (push) begin
            tail  <= in_ent;
            state <= FULL;
            rdy_q <= 1'b0;
          end else if (pop) begin
            state <= EMPTY;
            vld_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  // Accepted-operation counter. It wraps silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt <= '0;
    else if (push) cnt <= cnt + 1'b1;
  end

  assign o_ready    = rdy_q;
  assign o_valid    = vld_q;
  assign o_y        = head.y;
  assign o_overflow = head.ovf;
  assign o_err      = head.err;
  assign o_sel      = head.sel;
  assign o_op_cnt   = cnt;

`ifdef ALU_STICKY_FLAGS_EN
  logic sticky_ovf, sticky_err;

  // Sticky flags. A flag set by a push beats a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_ovf <= 1'b0;
      sticky_err <= 1'b0;
    end else begin
      sticky_ovf <= (sticky_ovf && !i_clr_flags) || (push && in_ent.ovf);
      sticky_err <= (sticky_err && !i_clr_flags) || (push && in_ent.err);
    end
  end

  assign o_sticky_ovf = sticky_ovf;
  assign o_sticky_err = sticky_err;
`else
  logic unused_clr;
  assign unused_clr   = i_clr_flags;
  assign o_sticky_ovf = 1'b0;
  assign o_sticky_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage. It combines directed table vectors with
// hand-written corner sequences and a randomized run. Expected values come
// from a queue-based reference model.
module tb_alu_result_stage;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_valid = 1'b0, i_ready = 1'b0, i_clr_flags = 1'b0;
  logic [1:0]         i_sel = '0;
  logic [4*WIDTH-1:0] i_y_all = '0;
  logic [3:0]         i_ovf_all = '0, i_err_all = '0;
  logic               o_ready, o_valid, o_overflow, o_err, o_sticky_ovf, o_sticky_err;
  logic [WIDTH-1:0]   o_y;
  logic [1:0]         o_sel;
  logic [CNT_W-1:0]   o_op_cnt;

  alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sel(i_sel), .i_y_all(i_y_all), .i_ovf_all(i_ovf_all), .i_err_all(i_err_all),
    .o_valid(o_valid), .i_ready(i_ready), .o_y(o_y), .o_overflow(o_overflow),
    .o_err(o_err), .o_sel(o_sel), .o_op_cnt(o_op_cnt), .i_clr_flags(i_clr_flags),
    .o_sticky_ovf(o_sticky_ovf), .o_sticky_err(o_sticky_err)
  );

  always #5 clk = ~clk;

`ifdef ALU_STICKY_FLAGS_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a plain FIFO of {y, ovf, err, sel} plus counters
  typedef struct {
    logic [3:0] y;
    logic       ovf;
    logic       err;
    logic [1:0] sel;
  } ent_t;
  ent_t q[$];
  int   m_cnt;
  bit   m_sovf, m_serr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = 0;
    m_sovf = 0;
    m_serr = 0;
  endtask

  task automatic check_model();
    chk("valid", o_valid, (q.size() > 0));
    chk("ready", o_ready, (q.size() < 2));
    chk("op_cnt", o_op_cnt, m_cnt % 256);
    chk("sticky_ovf", o_sticky_ovf, STICKY_EN & m_sovf);
    chk("sticky_err", o_sticky_err, STICKY_EN & m_serr);
    if (q.size() > 0) begin
      chk("y", o_y, q[0].y);
      chk("ovf", o_overflow, q[0].ovf);
      chk("err", o_err, q[0].err);
      chk("sel", o_sel, q[0].sel);
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, and compare.
  task automatic step(input logic v, input logic [1:0] s, input logic [15:0] y,
                      input logic [3:0] ov, input logic [3:0] er,
                      input logic rd, input logic cl);
    bit   psh, pp;
    ent_t e;
    i_valid = v; i_sel = s; i_y_all = y; i_ovf_all = ov; i_err_all = er;
    i_ready = rd; i_clr_flags = cl;
    psh = v && (q.size() < 2);
    pp  = rd && (q.size() > 0);
    e.y = y[s*4 +: 4]; e.ovf = ov[s]; e.err = er[s]; e.sel = s;
    @(posedge clk); #1;
    if (pp) void'(q.pop_front());
    if (psh) begin
      q.push_back(e);
      m_cnt++;
      if (e.ovf) m_sovf = 1;
      else if (cl) m_sovf = 0;
      if (e.err) m_serr = 1;
      else if (cl) m_serr = 0;
    end else if (cl) begin
      m_sovf = 0;
      m_serr = 0;
    end
    check_model();
  endtask

  task automatic do_reset();
    i_valid = 0; i_ready = 0; i_clr_flags = 0;
    rst_n = 0;
    #12;
    model_reset();
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_y", o_y, 0);
    chk("rst_sel", o_sel, 0);
    chk("rst_cnt", o_op_cnt, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic v; logic [1:0] s; logic [15:0] y; logic [3:0] ov, er; logic rd;
    logic e_vld, e_rdy; logic [3:0] e_y; logic e_ovf; logic [1:0] e_sel; logic [7:0] e_cnt;
  } vec_t;
  vec_t tbl[9];

  initial begin
    // Directed vectors, starting from reset with the counter at 0
    tbl[0] = '{1, 0, 16'h0009, 4'b0001, 4'b0000, 0, 1, 1, 4'h9, 1, 0, 1}; // single push
    tbl[1] = '{0, 0, 16'h0000, 4'b0000, 4'b0000, 1, 0, 1, 4'h0, 0, 0, 1}; // drain
    tbl[2] = '{1, 1, 16'hDCBA, 4'b1010, 4'b0100, 0, 1, 1, 4'hB, 1, 1, 2}; // push 01
    tbl[3] = '{1, 2, 16'hDCBA, 4'b1010, 4'b0100, 0, 1, 0, 4'hB, 1, 1, 3}; // push 10 -> full
    tbl[4] = '{1, 3, 16'hDCBA, 4'b1010, 4'b0100, 0, 1, 0, 4'hB, 1, 1, 3}; // refused
    tbl[5] = '{0, 0, 16'h0000, 4'b0000, 4'b0000, 1, 1, 1, 4'hC, 0, 2, 3}; // pop -> one
    tbl[6] = '{1, 3, 16'hDCBA, 4'b1010, 4'b0100, 1, 1, 1, 4'hD, 1, 3, 4}; // push+pop in one
    tbl[7] = '{0, 0, 16'h0000, 4'b0000, 4'b0000, 1, 0, 1, 4'h0, 0, 0, 4}; // empty
    tbl[8] = '{1, 2, 16'h0500, 4'b0000, 4'b0000, 0, 1, 1, 4'h5, 0, 2, 5}; // refill

    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].y, tbl[i].ov, tbl[i].er, tbl[i].rd, 1'b0);
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_ready", i), o_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_cnt", i), o_op_cnt, tbl[i].e_cnt);
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d_y", i), o_y, tbl[i].e_y);
        chk($sformatf("tbl%0d_ovf", i), o_overflow, tbl[i].e_ovf);
        chk($sformatf("tbl%0d_sel", i), o_sel, tbl[i].e_sel);
      end
    end

    // Streaming: the head should track each new push with no bubbles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [3:0] d;
      d = 4'(i);
      step(1, 2'(i), {4{d}}, 4'b0, 4'b0, 1, 0);
      chk("stream_valid", o_valid, 1);
      chk("stream_ready", o_ready, 1);
      chk("stream_y", o_y, d);
    end
    chk("stream_cnt", o_op_cnt, 10);

    // Sticky flags: a clear loses to a push carrying the same flag
    do_reset();
    step(1, 0, 16'h0, 4'b0, 4'b0001, 1, 0);
    chk("sticky_set", o_sticky_err, STICKY_EN);
    step(1, 0, 16'h0, 4'b0, 4'b0000, 1, 1);
    chk("sticky_clr", o_sticky_err, 0);
    step(1, 0, 16'h0, 4'b0, 4'b0001, 1, 0);
    step(1, 0, 16'h0, 4'b0, 4'b0001, 1, 1);
    chk("sticky_set_wins", o_sticky_err, STICKY_EN);

    // Asynchronous reset while FULL should clear the outputs immediately
    do_reset();
    step(1, 1, 16'h00F0, 4'b0010, 4'b0010, 0, 0);
    step(1, 1, 16'h00E0, 4'b0010, 4'b0010, 0, 0);
    chk("full_ready", o_ready, 0);
    #3 rst_n = 0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_ready", o_ready, 1);
    chk("arst_y", o_y, 0);
    chk("arst_ovf", o_overflow, 0);
    chk("arst_err", o_err, 0);
    chk("arst_cnt", o_op_cnt, 0);
    chk("arst_sticky", o_sticky_err, 0);
    do_reset();

    // Counter wrap: 256 pushes bring the counter back to 0
    for (int i = 0; i < 256; i++) step(1, 2'(i), 16'(i), 4'b0, 4'b0, 1, 0);
    chk("cnt_wrap", o_op_cnt, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 500; i++)
      step(1'($urandom), 2'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom), ($urandom_range(0, 7) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage placed directly downstream of the ALU operation library (subtractor, NAND, leading-ones counter, one-hot decoder). It takes the four parallel operation results and a per-transaction opcode, selects one result, and queues it with its overflow and error flags in a 2-entry buffer. The buffer drives a valid/ready handshake towards the display or consumer logic. The stage also keeps a wrapping count of accepted operations and, when configured, sticky status flags.

## Interface
Parameters:
- WIDTH, 4, result width; must equal the WIDTH of the operation modules.
- CNT_W, 8, width of the accepted-operation counter.

Ports:
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_valid  in  1  upstream offers a result set this cycle.
- o_ready  out  1  stage can accept; high when fewer than 2 entries are held.
- i_sel  in  2  result select: 00 subtractor, 01 nand_gate, 10 starting_ones, 11 onehot2u2_decoder.
- i_y_all  in  4*WIDTH  packed results; slice k is [k*WIDTH +: WIDTH], with k equal to the i_sel code.
- i_ovf_all  in  4  overflow flags; bit k belongs to code k.
- i_err_all  in  4  error flags; bit k belongs to code k.
- o_valid  out  1  head entry is valid.
- i_ready  in  1  downstream accepts the head entry.
- o_y  out  WIDTH  head result.
- o_overflow  out  1  head overflow flag.
- o_err  out  1  head error flag.
- o_sel  out  2  opcode tag of the head entry.
- o_op_cnt  out  CNT_W  count of accepted operations; wraps modulo 2^CNT_W.
- i_clr_flags  in  1  clears the sticky flags.
- o_sticky_ovf  out  1  sticky overflow flag.
- o_sticky_err  out  1  sticky error flag.

## Operation
- Push occurs when i_valid && o_ready. The entry stores {i_y_all slice[i_sel], i_ovf_all[i_sel], i_err_all[i_sel], i_sel}.
- Pop occurs when o_valid && i_ready. The head entry is removed and the next entry becomes head.
- The buffer has three states: EMPTY, ONE, FULL.
  - EMPTY: a push moves to ONE. A pop is impossible because o_valid=0.
  - ONE: a push alone moves to FULL. A pop alone moves to EMPTY. A push and pop in the same cycle stay in ONE, and the new entry becomes head.
  - FULL: o_ready=0 so no push occurs. A pop moves to ONE.
- Order is strictly FIFO. The head fields hold stable while o_valid=1 and i_ready=0.
- o_op_cnt increments by 1 on each push. It wraps from 2^CNT_W-1 to 0 with no flag.
- Sticky flags (see Configuration):
  - On a push, the sticky flags OR in the pushed overflow/error.
  - i_clr_flags clears them.
  - If a clear and a push with a flag set happen in the same cycle, the set wins and the flag ends at 1.
- Reset, at any time including mid-transfer, forces:
  - state EMPTY, o_valid=0, o_ready=1;
  - o_y=0, o_overflow=0, o_err=0, o_sel=0;
  - o_op_cnt=0, sticky flags 0.
  - Buffered entries are discarded.

## Timing
- Latency is 1 cycle: a push at edge N makes o_valid=1 with the data from edge N (when the buffer was EMPTY).
- o_ready and o_valid are driven from registers only. There is no combinational path from i_valid or i_ready to any output.
- Throughput is 1 entry per cycle when i_ready is held high. The 2-entry depth gives full throughput despite the registered o_ready.
- o_op_cnt and the sticky flags update on the same edge as the push.

## Configuration
- ALU_STICKY_FLAGS_EN defined: sticky registers exist and behave as in Operation.
- ALU_STICKY_FLAGS_EN undefined: o_sticky_ovf and o_sticky_err are tied to 0, i_clr_flags is ignored, and no sticky registers are synthesized.
- All other behaviour is identical in both builds.

## Test plan
- Reset then single push: WIDTH=4, i_sel=00, slice0=4'b1001, ovf=1 -> one cycle later o_valid=1, o_y=9, o_overflow=1, o_sel=0, o_op_cnt=1.
- Backpressure: push 3 entries (codes 01, 10, 11) with i_ready=0 -> o_ready drops after the 2nd push, the 3rd push is not accepted, o_op_cnt=2, head stays code 01.
- Drain with a simultaneous push in ONE: push A, then push B and pop A in the same cycle -> state stays ONE, head becomes B, o_op_cnt=2.
- Streaming: i_valid=1 and i_ready=1 for 10 cycles with incrementing data -> 10 outputs in order, no bubbles after the first, o_ready never drops.
- Sticky flags (macro defined): push with err=1, then assert i_clr_flags together with a push where err=0 -> o_sticky_err goes 1 then 0. Clear together with a push where err=1 -> stays 1. Macro undefined -> o_sticky_err stays 0.
- Asynchronous reset while FULL, plus counter wrap: assert i_rst_n=0 mid-cycle -> outputs reset immediately. Separately, 256 pushes with CNT_W=8 -> o_op_cnt returns to 0.
